// File: rtl/adj_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adj_button_ctrl
// Brief    : Converts two raw push-buttons into clean single-cycle inc/dec
//            pulses for the clock's adjust counters. Each button goes through
//            a 2-FF synchroniser and a debouncer. A press-and-hold then
//            auto-repeats, and pressing up+down together locks out all pulses.
// Options  : `define ADJ_STOP_AT_LIMIT_EN makes auto-repeat stop (LOCK) after
//            the pulse on which the counter reports its limit via
//            done_inc/done_dec. Without it those inputs are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module adj_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 500,
    parameter int REPEAT_CYCLES   = 100,
    parameter int TIMER_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic done_inc,
    input  logic done_dec,
    output logic inc,
    output logic dec,
    output logic adj_en,
    output logic repeating
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;
    localparam logic [1:0] c_ST_LOCK   = 2'd3;

    localparam logic c_DIR_UP   = 1'b1;
    localparam logic c_DIR_DOWN = 1'b0;

    // A repeat period of 1 would merge pulses; the shortest legal period is 2.
    localparam int c_REPEAT_PERIOD = (REPEAT_CYCLES < 2) ? 2 : REPEAT_CYCLES;

    localparam logic [TIMER_W-1:0] c_DEB_LAST    = TIMER_W'(DEBOUNCE_CYCLES);
    localparam logic [TIMER_W-1:0] c_HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_REPEAT_LAST = TIMER_W'(c_REPEAT_PERIOD - 1);
    localparam logic [TIMER_W-1:0] c_TIMER_ONE   = TIMER_W'(1);

    // bit 0 = up button, bit 1 = down button
    logic [1:0] w_raw;
    logic [1:0] w_deb;
    logic       w_up;
    logic       w_dn;

    assign w_raw = {btn_down, btn_up};
    assign w_up  = w_deb[0];
    assign w_dn  = w_deb[1];

    // ------------------------------------------------------------------------
    // Per-button synchroniser and debouncer
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_deb;
            logic [TIMER_W-1:0] r_cnt;

            // Sync the raw level, then flip the debounced level on the edge
            // after the disagreement counter has reached DEBOUNCE_CYCLES.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 != r_deb) begin
                        if (r_cnt == c_DEB_LAST) begin
                            r_deb <= ~r_deb;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_TIMER_ONE;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Adjust FSM
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic               w_timer_clr;
    logic               w_fire;
    logic               w_act;
    logic               w_oth;
    logic               w_limit_hit;
    logic               w_inc_nxt;
    logic               w_dec_nxt;
    logic               w_repeating;
    logic               r_inc;
    logic               r_dec;
    logic               r_adj_en;

    // Button driving the current hold, and the opposing one.
    assign w_act = (r_dir == c_DIR_UP) ? w_up : w_dn;
    assign w_oth = (r_dir == c_DIR_UP) ? w_dn : w_up;

`ifdef ADJ_STOP_AT_LIMIT_EN
    logic r_lockable;

    // Remember that the pulse now on the outputs was issued from HOLD/REPEAT;
    // pulses from IDLE (single presses) are always allowed to wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lockable <= 1'b0;
        end else begin
            r_lockable <= w_fire && (r_state != c_ST_IDLE);
        end
    end

    assign w_limit_hit = r_lockable && ((r_dir == c_DIR_UP) ? done_inc : done_dec);
`else
    logic w_unused_done;

    assign w_unused_done = done_inc ^ done_dec;
    assign w_limit_hit   = 1'b0;
`endif

    // State, latched direction and the shared hold/repeat timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_dir   <= c_DIR_DOWN;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_timer <= w_timer_clr ? '0 : (r_timer + c_TIMER_ONE);
        end
    end

    // Next state: release beats a due pulse, the opposing button forces LOCK.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_fire      = 1'b0;
        w_timer_clr = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                if (w_up && !w_dn) begin
                    w_state_nxt = c_ST_HOLD;
                    w_dir_nxt   = c_DIR_UP;
                    w_fire      = 1'b1;
                end else if (w_dn && !w_up) begin
                    w_state_nxt = c_ST_HOLD;
                    w_dir_nxt   = c_DIR_DOWN;
                    w_fire      = 1'b1;
                end else if (w_up && w_dn) begin
                    w_state_nxt = c_ST_LOCK;
                end
            end
            c_ST_HOLD: begin
                if (w_limit_hit) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (!w_act) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_oth) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (r_timer == c_HOLD_LAST) begin
                    w_state_nxt = c_ST_REPEAT;
                    w_fire      = 1'b1;
                end else begin
                    w_timer_clr = 1'b0;
                end
            end
            c_ST_REPEAT: begin
                if (w_limit_hit) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (!w_act) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_oth) begin
                    w_state_nxt = c_ST_LOCK;
                end else if (r_timer == c_REPEAT_LAST) begin
                    w_fire = 1'b1;
                end else begin
                    w_timer_clr = 1'b0;
                end
            end
            c_ST_LOCK: begin
                if (!w_up && !w_dn) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: steer the pulse by direction, flag the REPEAT state.
    always_comb begin
        w_inc_nxt   = w_fire && (w_dir_nxt == c_DIR_UP);
        w_dec_nxt   = w_fire && (w_dir_nxt == c_DIR_DOWN);
        w_repeating = (r_state == c_ST_REPEAT);
    end

    // Register the pulses so they are glitch-free single-cycle strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inc    <= 1'b0;
            r_dec    <= 1'b0;
            r_adj_en <= 1'b0;
        end else begin
            r_inc    <= w_inc_nxt;
            r_dec    <= w_dec_nxt;
            r_adj_en <= w_fire;
        end
    end

    assign inc       = r_inc;
    assign dec       = r_dec;
    assign adj_en    = r_adj_en;
    assign repeating = w_repeating;

endmodule
`default_nettype wire

// File: tb/tb_adj_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adj_button_ctrl
// Brief    : Scoreboard bench for adj_button_ctrl. Directed test-plan
//            scenarios are followed by randomized button activity. A
//            behavioural model pushes the expected outputs of every clock
//            edge, and a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adj_button_ctrl;

    localparam int D  = 4;
    localparam int H  = 20;
    localparam int R  = 5;
    localparam int TW = 16;
    localparam int P  = (R < 2) ? 2 : R;
`ifdef ADJ_STOP_AT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    logic reset;
    logic btn_up;
    logic btn_down;
    logic done_inc;
    logic done_dec;
    logic inc;
    logic dec;
    logic adj_en;
    logic repeating;

    always #5 clk = ~clk;

    adj_button_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .TIMER_W        (TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .done_inc (done_inc),
        .done_dec (done_dec),
        .inc      (inc),
        .dec      (dec),
        .adj_en   (adj_en),
        .repeating(repeating)
    );

    typedef struct {
        int   cyc;
        logic inc;
        logic dec;
        logic rep;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = -1;
    int   k     = 0;

    // pulse log filled by the monitor, used by the directed timing checks
    int pl_cyc[$];
    bit pl_up[$];
    int rep_rise = -1;

    // behavioural model state
    bit m_s1[2];
    bit m_s2[2];
    bit m_deb[2];
    int m_run[2];
    int m_mode;
    bit m_dir;
    int m_start;
    bit m_last_rep_pulse;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs after edge k, from the debounce and hold/repeat rules.
    task automatic model_step(input int kk);
        exp_t e;
        bit   up, dn, act, oth, pulse, from_active;
        bit   raw[2];
        int   el;
        e.cyc = kk; e.inc = 1'b0; e.dec = 1'b0; e.rep = 1'b0;
        raw[0] = btn_up;
        raw[1] = btn_down;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_run[b] = 0;
            end
            m_mode = M_IDLE; m_dir = 0; m_start = 0; m_last_rep_pulse = 0;
        end else begin
            up = m_deb[0];
            dn = m_deb[1];
            pulse = 0;
            from_active = 0;
            case (m_mode)
                M_IDLE: begin
                    if (up && !dn) begin
                        m_mode = M_ACTIVE; m_dir = 1; m_start = kk; pulse = 1;
                    end else if (dn && !up) begin
                        m_mode = M_ACTIVE; m_dir = 0; m_start = kk; pulse = 1;
                    end else if (up && dn) begin
                        m_mode = M_LOCKED;
                    end
                end
                M_ACTIVE: begin
                    act = m_dir ? up : dn;
                    oth = m_dir ? dn : up;
                    el  = kk - m_start;
                    if (LIMIT_EN && m_last_rep_pulse && (m_dir ? done_inc : done_dec))
                        m_mode = M_LOCKED;
                    else if (!act)
                        m_mode = M_IDLE;
                    else if (oth)
                        m_mode = M_LOCKED;
                    else if (el >= H && ((el - H) % P) == 0) begin
                        pulse = 1;
                        from_active = 1;
                    end
                end
                default: begin
                    if (!up && !dn) m_mode = M_IDLE;
                end
            endcase
            m_last_rep_pulse = from_active;
            e.inc = pulse && m_dir;
            e.dec = pulse && !m_dir;
            e.rep = (m_mode == M_ACTIVE) && ((kk - m_start) >= H);
            // debounced level follows the synced level once it has disagreed
            // for D+1 consecutive edges
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    if (m_run[b] == D) begin
                        m_deb[b] = ~m_deb[b];
                        m_run[b] = 0;
                    end else begin
                        m_run[b]++;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
        q.push_back(e);
    endtask

    // Model the coming edge with the current inputs, then let it happen.
    task automatic tick();
        model_step(k);
        @(negedge clk);
        k++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        pl_cyc.delete();
        pl_up.delete();
        rep_rise = -1;
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (inc || dec) begin
                pl_cyc.push_back(cyc);
                pl_up.push_back(inc);
            end
            if (repeating && rep_rise < 0) rep_rise = cyc;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: edge %0d got inc=%b dec=%b", cyc, inc, dec);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || inc !== e.inc || dec !== e.dec ||
                    adj_en !== (e.inc | e.dec) || repeating !== e.rep) begin
                    bad++;
                    $display("FAIL outputs edge %0d (exp edge %0d): got inc=%b dec=%b adj_en=%b rep=%b want inc=%b dec=%b adj_en=%b rep=%b",
                             cyc, e.cyc, inc, dec, adj_en, repeating, e.inc, e.dec, e.inc | e.dec, e.rep);
                end
            end
        end
    end

    initial begin
        int p, t, t_rel, n_exp, r_edge;
        int exp_list[$];

        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; done_inc = 1'b0; done_dec = 1'b0;
        run(3);
        chk("reset_inc", int'(inc), 0);
        chk("reset_dec", int'(dec), 0);
        chk("reset_adj_en", int'(adj_en), 0);
        chk("reset_repeating", int'(repeating), 0);
        reset = 1'b0;
        run(5);

        // single press: one inc, D+3 edges after the press is first sampled
        clear_log();
        p = k;
        btn_up = 1'b1; run(10);
        btn_up = 1'b0; run(25);
        chk("single_count", pl_cyc.size(), 1);
        if (pl_cyc.size() > 0) begin
            chk("single_time", pl_cyc[0], p + D + 3);
            chk("single_is_inc", int'(pl_up[0]), 1);
        end
        chk("single_no_repeat", rep_rise, -1);

        // bounce: toggling down button, then stable high
        clear_log();
        p = k;
        for (int i = 0; i < 12; i++) begin
            btn_down = ((i / 2) % 2) == 0;
            tick();
        end
        btn_down = 1'b1; run(15);
        btn_down = 1'b0; run(25);
        chk("bounce_count", pl_cyc.size(), 1);
        if (pl_cyc.size() > 0) begin
            chk("bounce_time", pl_cyc[0], p + 12 + D + 3);
            chk("bounce_is_dec", int'(pl_up[0]), 0);
        end

        // hold: first pulse, second after H, then every P; release wins a tie
        clear_log();
        p = k;
        btn_up = 1'b1; run(60);
        btn_up = 1'b0; run(30);
        t_rel = p + 60 + D + 3;
        exp_list.delete();
        t = p + D + 3;
        while (t < t_rel) begin
            exp_list.push_back(t);
            t = (t == p + D + 3) ? t + H : t + P;
        end
        chk("hold_count", pl_cyc.size(), exp_list.size());
        for (int i = 0; i < exp_list.size(); i++)
            if (i < pl_cyc.size()) chk("hold_pulse_time", pl_cyc[i], exp_list[i]);
        chk("hold_repeat_start", rep_rise, p + D + 3 + H);

        // conflict: down joins a held up button; nothing until both released
        clear_log();
        p = k;
        btn_up = 1'b1; run(15);
        btn_down = 1'b1; run(25);
        btn_up = 1'b0; btn_down = 1'b0; run(15);
        t = k;
        btn_down = 1'b1; run(10);
        btn_down = 1'b0; run(20);
        chk("conflict_count", pl_cyc.size(), 2);
        if (pl_cyc.size() == 2) begin
            chk("conflict_first", pl_cyc[0], p + D + 3);
            chk("conflict_after_release", pl_cyc[1], t + D + 3);
            chk("conflict_after_is_dec", int'(pl_up[1]), 0);
        end

        // reset mid-hold: outputs clear at once, held button is a new press
        p = k;
        btn_up = 1'b1; run(30);
        reset = 1'b1;
        #1;
        chk("midreset_repeating", int'(repeating), 0);
        chk("midreset_inc", int'(inc), 0);
        chk("midreset_adj_en", int'(adj_en), 0);
        clear_log();
        run(2);
        reset = 1'b0;
        r_edge = k;
        run(15);
        btn_up = 1'b0; run(20);
        chk("midreset_count", pl_cyc.size(), 1);
        if (pl_cyc.size() > 0) chk("midreset_time", pl_cyc[0], r_edge + D + 3);

        // limit flag coincident with the third pulse
        clear_log();
        p = k;
        btn_up = 1'b1;
        for (int i = 0; i < 60; i++) begin
            done_inc = (k == p + D + 3 + H + P + 1);
            tick();
        end
        done_inc = 1'b0;
        btn_up = 1'b0; run(30);
        n_exp = LIMIT_EN ? 3 : 9;
        chk("limit_count", pl_cyc.size(), n_exp);

        // randomized activity checked only through the scoreboard
        for (int seg = 0; seg < 150; seg++) begin
            int kind, len;
            kind = $urandom_range(0, 19);
            len  = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0, 1, 2, 3: begin btn_up = 0; btn_down = 0; end
                    4, 5, 6, 7: begin btn_up = 1; btn_down = 0; end
                    8, 9, 10, 11: begin btn_up = 0; btn_down = 1; end
                    12, 13: begin btn_up = 1; btn_down = 1; end
                    14, 15: begin btn_up = (i % 3) != 0; btn_down = 0; end
                    16, 17: begin btn_up = $urandom_range(0, 1); btn_down = $urandom_range(0, 1); end
                    default: ;
                endcase
                done_inc = ($urandom_range(0, 7) == 0);
                done_dec = ($urandom_range(0, 7) == 0);
                reset = (kind == 19) && (i < 2);
                tick();
            end
            reset = 1'b0;
        end
        btn_up = 0; btn_down = 0; done_inc = 0; done_dec = 0;
        run(40);
        chk("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
